// File: rtl/wc_seq.sv
// wc_seq: loads a 3x3 kernel and a 4x4 tile into the convolution core, starts it,
// then drains the 2x2 result tile. Define WC_WDOG_EN to add a core-completion watchdog.
module wc_seq #(
    parameter int DW       = 10,
    parameter int WDOG_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          core_ld_en,
    output logic          core_ld_sel,
    output logic [3:0]    core_ld_addr,
    output logic [DW-1:0] core_ld_data,
    output logic          core_start,
    input  logic          core_done,
    output logic [1:0]    core_rd_addr,
    input  logic [DW-1:0] core_z,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE,
        LD_K,
        LD_T,
        START,
        WAIT,
        RD_REQ,
        RD_OUT
    } state_t;

    localparam logic [3:0] KERN_LAST = 4'd8;
    localparam logic [3:0] TILE_LAST = 4'd15;
    localparam logic [1:0] RES_LAST  = 2'd3;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [1:0]    rd_addr_q, rd_addr_d;
    logic [DW-1:0] out_data_q, out_data_d;

`ifdef WC_WDOG_EN
    // Counter only has to reach WDOG_CYC-1: the timeout fires in the last allowed WAIT cycle.
    localparam int WW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;

    logic [WW-1:0] wd_cnt_q, wd_cnt_d;
    logic          err_q, err_d;
`endif

    // NOTE: every signal written here gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_addr_d    = rd_addr_q;
        out_data_d   = out_data_q;
        in_ready     = 1'b0;
        core_ld_en   = 1'b0;
        core_ld_sel  = 1'b0;
        core_ld_data = '0;
        core_start   = 1'b0;
        out_valid    = 1'b0;
`ifdef WC_WDOG_EN
        wd_cnt_d     = wd_cnt_q;
        err_d        = err_q;
`endif

        case (state_q)
            IDLE: begin
                // The word that wakes the sequencer is taken on the following cycle.
                if (in_valid) begin
                    state_d = LD_K;
                    cnt_d   = '0;
                end
            end

            LD_K: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    core_ld_en   = 1'b1;
                    core_ld_data = in_data;
                    if (cnt_q == KERN_LAST) begin
                        cnt_d   = '0;
                        state_d = LD_T;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            LD_T: begin
                in_ready    = 1'b1;
                core_ld_sel = 1'b1;
                if (in_valid) begin
                    core_ld_en   = 1'b1;
                    core_ld_data = in_data;
                    if (cnt_q == TILE_LAST) begin
                        cnt_d   = '0;
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            START: begin
                core_start = 1'b1;
                state_d    = WAIT;
`ifdef WC_WDOG_EN
                wd_cnt_d   = '0;
`endif
            end

            WAIT: begin
                if (core_done) begin
                    state_d   = RD_REQ;
                    rd_addr_d = '0;
                end
`ifdef WC_WDOG_EN
                else if (wd_cnt_q == WW'(WDOG_CYC - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + WW'(1);
                end
`endif
            end

            RD_REQ: begin
                // The core answers the address presented this cycle; sample it on exit.
                state_d    = RD_OUT;
                out_data_d = core_z;
            end

            RD_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (rd_addr_q == RES_LAST) begin
                        rd_addr_d = '0;
                        state_d   = IDLE;
                    end else begin
                        rd_addr_d = rd_addr_q + 2'd1;
                        state_d   = RD_REQ;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples the
    // pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_addr_q  <= '0;
            out_data_q <= '0;
`ifdef WC_WDOG_EN
            wd_cnt_q   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_addr_q  <= rd_addr_d;
            out_data_q <= out_data_d;
`ifdef WC_WDOG_EN
            wd_cnt_q   <= wd_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign core_ld_addr = cnt_q;
    assign core_rd_addr = rd_addr_q;
    assign out_data     = out_data_q;
    assign busy         = (state_q != IDLE);

`ifdef WC_WDOG_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_wc_seq.sv
// Bench for wc_seq: directed frames with a queue-based scoreboard and a behavioural core.
module tb_wc_seq;

    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          core_ld_en;
    logic          core_ld_sel;
    logic [3:0]    core_ld_addr;
    logic [DW-1:0] core_ld_data;
    logic          core_start;
    logic          core_done;
    logic [1:0]    core_rd_addr;
    logic [DW-1:0] core_z;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          err;

    wc_seq #(.DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .core_ld_en   (core_ld_en),
        .core_ld_sel  (core_ld_sel),
        .core_ld_addr (core_ld_addr),
        .core_ld_data (core_ld_data),
        .core_start   (core_start),
        .core_done    (core_done),
        .core_rd_addr (core_rd_addr),
        .core_z       (core_z),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          sel;
        logic [3:0]    addr;
        logic [DW-1:0] data;
    } ld_t;

    ld_t           ld_q[$];
    logic [DW-1:0] res_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int ld_cnt    = 0;
    int start_cnt = 0;
    int busy_cyc  = 0;
    int acc_cnt   = 0;

    // Behavioural core: result word = address + 100, done pulse core_lat cycles into WAIT.
    logic model_done = 1'b0;
    logic spur_done;
    bit   core_en;
    int   core_lat;

    assign core_z    = DW'(core_rd_addr) + DW'(100);
    assign core_done = model_done | spur_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({in_ready, core_ld_en, core_ld_sel, core_ld_addr, core_ld_data, core_start,
                    core_rd_addr, out_valid, out_data, busy, err});
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (core_start && core_en) begin
                repeat (core_lat) @(posedge clk);
                #1 model_done = 1'b1;
                @(posedge clk);
                #1 model_done = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a load strobe or a result.
    ld_t           e_ld;
    logic [DW-1:0] e_res;
    logic [DW-1:0] hold_val;
    bit            hold_pend = 1'b0;

    always @(negedge clk) begin
        if (core_ld_en) begin
            ld_cnt++;
            if (ld_q.size() == 0) begin
                check("ld_unexpected", 64'(core_ld_en), 64'(0));
            end else begin
                e_ld = ld_q.pop_front();
                check("ld_word", 64'({core_ld_sel, core_ld_addr, core_ld_data}), 64'(e_ld));
            end
        end
        if (core_start) start_cnt++;
        if (busy) busy_cyc++;
        if (hold_pend && out_valid) check("out_hold", 64'(out_data), 64'(hold_val));
        hold_pend = 1'b0;
        if (out_valid) begin
            if (out_ready) begin
                acc_cnt++;
                if (res_q.size() == 0) begin
                    check("out_unexpected", 64'(out_valid), 64'(0));
                end else begin
                    e_res = res_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e_res));
                end
            end else begin
                hold_pend = 1'b1;
                hold_val  = out_data;
            end
        end
    end

    task automatic send_word(input logic sel, input logic [3:0] addr, input logic [DW-1:0] d);
        ld_t w;
        int  n = 0;
        w.sel  = sel;
        w.addr = addr;
        w.data = d;
        ld_q.push_back(w);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input int gap_after, input int n_tiles, input bit spur);
        for (int k = 0; k < 9; k++) begin
            if (k == 3 && spur) spur_done = 1'b1;
            send_word(1'b0, 4'(k), DW'(k + 1));
            spur_done = 1'b0;
            if (k + 1 == gap_after) begin
                in_valid = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("gap_no_ld", 64'(core_ld_en), 64'(0));
                    @(posedge clk);
                    #1;
                end
            end
        end
        for (int t = 0; t < n_tiles; t++) send_word(1'b1, 4'(t), DW'(10 + t));
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int target, input int st_idx, input int st_n);
        int stalled = 0;
        int n       = 0;
        while (acc_cnt < target && n < 400) begin
            @(posedge clk);
            #1;
            if (out_valid && acc_cnt == st_idx && stalled < st_n) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = 1'b1;
            end
            n++;
        end
        out_ready = 1'b1;
        if (acc_cnt < target) check("result_timeout", 64'(acc_cnt), 64'(target));
    endtask

    task automatic run_frame(input int gap_after, input int lat, input int stall_n,
                             input bit spur, input int exp_busy);
        int b_ld   = ld_cnt;
        int b_st   = start_cnt;
        int b_busy = busy_cyc;
        int b_acc  = acc_cnt;
        core_lat = lat;
        for (int i = 0; i < 4; i++) res_q.push_back(DW'(100 + i));
        load_frame(gap_after, 16, spur);
        wait_results(b_acc + 4, b_acc + 1, stall_n);
        @(negedge clk);
        check("frame_idle", 64'(busy), 64'(0));
        check("frame_ld_count", 64'(ld_cnt - b_ld), 64'(25));
        check("frame_start_count", 64'(start_cnt - b_st), 64'(1));
        check("frame_busy_cycles", 64'(busy_cyc - b_busy), 64'(exp_busy));
        check("frame_res_left", 64'(res_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int w;
        int a0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        spur_done = 1'b0;
        core_en   = 1'b1;
        core_lat  = 6;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", out_vec(), 64'(0));
        @(posedge clk);
        #1 rst = 1'b1;

        // Stray completion pulse while idle must not wake the sequencer.
        spur_done = 1'b1;
        @(posedge clk);
        #1 spur_done = 1'b0;
        @(negedge clk);
        check("idle_spur_busy", 64'(busy), 64'(0));
        check("idle_spur_outs", out_vec(), 64'(0));
        @(posedge clk);
        #1;

        // Continuous load, latency 6, result 1 stalled two cycles: 9+16+1+6+8+2 busy cycles.
        run_frame(-1, 6, 2, 1'b0, 42);
        // 3-cycle gap after kernel word 5, latency 3, stray done in LD_K: 9+16+3+1+3+8.
        run_frame(5, 3, 0, 1'b1, 40);

        // Abandon a frame after 7 tile words.
        a0 = acc_cnt;
        n  = ld_cnt;
        load_frame(-1, 7, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midframe_reset_outs", out_vec(), 64'(0));
        check("midframe_ld_count", 64'(ld_cnt - n), 64'(16));
        check("midframe_ld_left", 64'(ld_q.size()), 64'(0));
        repeat (10) @(negedge clk);
        check("midframe_no_result", 64'(acc_cnt - a0), 64'(0));
        check("midframe_still_idle", 64'(busy), 64'(0));
        @(posedge clk);
        #1;

        run_frame(-1, 6, 0, 1'b0, 40);

        // Core never completes.
        core_en = 1'b0;
        load_frame(-1, 16, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!core_start && n < 100);
        check("wdog_start_seen", 64'(core_start), 64'(1));
        w = 0;
        @(negedge clk);
        while (busy && w < 300) begin
            w++;
            @(negedge clk);
        end
`ifdef WC_WDOG_EN
        check("wdog_wait_cycles", 64'(w), 64'(255));
        check("wdog_idle", 64'(busy), 64'(0));
        check("wdog_err", 64'(err), 64'(1));
        repeat (5) @(negedge clk);
        check("wdog_err_sticky", 64'(err), 64'(1));
`else
        check("wait_unbounded_cycles", 64'(w), 64'(300));
        check("wait_unbounded_busy", 64'(busy), 64'(1));
        check("wait_no_err", 64'(err), 64'(0));
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_after_wait", out_vec(), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, got %0d/%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule

// File: doc/wc_seq.md
WC_SEQ -- requirements
Module: wc_seq

Interface
REQ-001 Parameter DW, default 10, data word width; matches the pad bus and the WC_3_4 D/Z width.
REQ-002 Parameter WDOG_CYC, default 255, watchdog limit in cycles for core completion (used only under WC_WDOG_EN).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  host word valid.
REQ-006 in_ready  output  1  sequencer accepts host word.
REQ-007 in_data  input  DW  host word (kernel words first, then tile words).
REQ-008 core_ld_en  output  1  write strobe into the core operand buffer.
REQ-009 core_ld_sel  output  1  0 = kernel buffer, 1 = tile buffer.
REQ-010 core_ld_addr  output  4  operand buffer address.
REQ-011 core_ld_data  output  DW  operand word.
REQ-012 core_start  output  1  one-cycle compute start pulse.
REQ-013 core_done  input  1  one-cycle compute-complete pulse from the core.
REQ-014 core_rd_addr  output  2  result address, 0..3 (2x2 output tile).
REQ-015 core_z  input  DW  result word; valid one cycle after core_rd_addr is presented.
REQ-016 out_valid  output  1  result word valid.
REQ-017 out_ready  input  1  downstream accepts result word.
REQ-018 out_data  output  DW  result word.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 err  output  1  sticky watchdog error flag.

Function
REQ-021 States SHALL be IDLE, LD_K, LD_T, START, WAIT, RD_REQ, RD_OUT.
REQ-022 IDLE -> LD_K when in_valid=1; no word is accepted in the IDLE cycle itself.
REQ-023 in_ready SHALL be 1 only in LD_K and LD_T; a word transfers on in_valid&&in_ready.
REQ-024 Each transfer SHALL drive core_ld_en=1 in the same cycle, with core_ld_data=in_data, core_ld_addr=word count, core_ld_sel=0 in LD_K and 1 in LD_T.
REQ-025 LD_K SHALL accept exactly 9 words (addr 0..8), then go to LD_T; LD_T SHALL accept exactly 16 words (addr 0..15), then go to START; the address counter clears on each of these transitions.
REQ-026 in_valid low during LD_K/LD_T SHALL stall with no state or counter change.
REQ-027 START SHALL assert core_start for exactly one cycle, then enter WAIT.
REQ-028 WAIT -> RD_REQ on core_done=1 with core_rd_addr=0; core_done outside WAIT SHALL be ignored.
REQ-029 RD_REQ presents core_rd_addr for one cycle, then enters RD_OUT, capturing core_z into out_data on that edge.
REQ-030 In RD_OUT, out_valid=1 and out_data SHALL hold stable until out_ready=1.
REQ-031 On acceptance of result 0..2, increment core_rd_addr and return to RD_REQ; on acceptance of result 3, return to IDLE.
REQ-032 Back-to-back frames: IDLE re-entry SHALL take one cycle; minimum frame length = 1+9+16+1+(core latency)+4x2 cycles.
REQ-033 Outputs not named as active in a state SHALL be 0 (core_ld_en, core_start, out_valid).

Reset
REQ-034 rst=0 sampled at a clock edge SHALL force IDLE, clear all counters, and drive in_ready=0, core_ld_en=0, core_ld_sel=0, core_ld_addr=0, core_ld_data=0, core_start=0, core_rd_addr=0, out_valid=0, out_data=0, busy=0, err=0.
REQ-035 Reset mid-frame SHALL abandon the frame; no partial result SHALL be emitted after reset.

Configuration
REQ-036 With WC_WDOG_EN defined: a WAIT cycle counter SHALL run, and if it reaches WDOG_CYC without core_done, the FSM goes to IDLE and err is set to 1 until reset.
REQ-037 Without WC_WDOG_EN: WAIT is unbounded, no watchdog counter exists, err SHALL be tied to 0.

Verification
REQ-038 Stream kernel 1..9 and tile 10..25 with continuous in_valid -> 25 core_ld_en pulses, sel/addr sequence 0/0..8 then 1/0..15, one core_start.
REQ-039 Drop in_valid for 3 cycles after word 5 -> no ld strobes during the gap, addresses resume at 5 with no skip or duplicate.
REQ-040 core_done after 6 cycles, core_z=addr+100, out_ready low for 2 cycles on word 1 -> out_data 100,101,102,103 in order, word 1 held stable while stalled.
REQ-041 rst=0 during LD_T word 7 -> next cycle IDLE with all outputs at reset values; new frame starts cleanly at kernel addr 0.
REQ-042 WC_WDOG_EN, WDOG_CYC=255, core_done never asserted -> IDLE after 255 WAIT cycles, err=1 until rst; without the macro the FSM stays in WAIT and err=0.
REQ-043 Spurious core_done in IDLE or LD_K -> no state change.
